// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_TRAP  = 3'd0,
    SEL_REDIR = 3'd1,
    SEL_RAS   = 3'd2,
    SEL_SEQ   = 3'd3,
    SEL_HOLD  = 3'd4
  } pc_sel_e;

  localparam int unsigned DEF_ADDR_W    = 32;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0080;
  localparam int unsigned DEF_STEP      = 4;
  localparam int unsigned DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push/pop/top, same-cycle push+pop replaces the
// top entry, a push when full silently overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_val,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int unsigned      PTR_W   = $clog2(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [ADDR_W-1:0] mem_d [RAS_DEPTH];
  logic [PTR_W-1:0]  tp_q, tp_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              do_pop;

  // A pop on an empty stack is dropped so the count can never underflow.
  assign do_pop = pop & (cnt_q != '0);

  always_comb begin
    mem_d = mem_q;
    tp_d  = tp_q;
    cnt_d = cnt_q;
    if (push && do_pop) begin
      mem_d[tp_q] = push_val;
    end else if (push) begin
      tp_d        = tp_q + PTR_ONE;
      mem_d[tp_d] = push_val;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (do_pop) begin
      tp_d  = tp_q - PTR_ONE;
      cnt_d = cnt_q - CNT_ONE;
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tp_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      tp_q    <= tp_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // Entry storage carries no reset; the count alone decides what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign top   = mem_q[tp_q];
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator. Handshake: IF_Addr is offered while IF_Valid=1 and is
// consumed on a rising edge where IF_Valid & IF_Ready & En are all 1 (in RUN).
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(DEF_TRAP_VEC),
  parameter int unsigned       STEP      = DEF_STEP,
  parameter int unsigned       RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              En,
  input  logic              IF_Ready,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] Redirect_Addr,
  input  logic              Trap,
  input  logic              Call_Push,
  input  logic              Ret_Pop,
  output logic [ADDR_W-1:0] IF_Addr,
  output logic              IF_Valid,
  output logic              Ras_Empty,
  output logic              Ras_Full,
  output pc_state_e         dbg_state
);

  localparam logic [ADDR_W-1:0] STEP_V     = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STEP - 1);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  pc_sel_e           sel;
  logic              adv;
  logic [ADDR_W-1:0] seq_addr;
  logic              ras_push, ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty, ras_full;

  always_comb begin
    adv      = (state_q == ST_RUN) & valid_q & IF_Ready & En;
    seq_addr = addr_q + STEP_V;

    // adv is never set outside RUN, so one priority chain serves every state.
    if (Trap) begin
      sel = SEL_TRAP;
    end else if (Redirect) begin
      sel = SEL_REDIR;
    end else if (adv && Ret_Pop && !ras_empty) begin
      sel = SEL_RAS;
    end else if (adv) begin
      sel = SEL_SEQ;
    end else begin
      sel = SEL_HOLD;
    end

    ras_push = adv & Call_Push & ~Trap & ~Redirect;
    ras_pop  = (sel == SEL_RAS);

    case (sel)
      SEL_TRAP:  addr_d = TRAP_VEC;
      SEL_REDIR: addr_d = Redirect_Addr & ALIGN_MASK;
      SEL_RAS:   addr_d = ras_top;
      SEL_SEQ:   addr_d = seq_addr;
      default:   addr_d = addr_q;
    endcase

    case (sel)
      SEL_TRAP, SEL_REDIR: state_d = ST_FLUSH;
      default:             state_d = ST_RUN;
    endcase

    valid_d = (state_d == ST_RUN);
  end

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      state_q <= ST_BOOT;
      addr_q  <= RESET_VEC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (Clk),
    .rst_n    (Clrn),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_val (seq_addr),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

  assign IF_Addr   = addr_q;
  assign IF_Valid  = valid_q;
  assign Ras_Empty = ras_empty;
  assign Ras_Full  = ras_full;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a 32-bit default instance and an 8-bit wrap/trap instance.
module tb_pc_gen;
  import pc_pkg::*;

  localparam int W  = 37;
  localparam int W8 = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clrn, en, if_ready, redirect, trap, call_push, ret_pop;
  logic [31:0] redirect_addr;
  logic [31:0] if_addr;
  logic        if_valid, ras_empty, ras_full;
  pc_state_e   dbg_state;

  logic        s_clrn, s_trap;
  logic [7:0]  s_addr;
  logic        s_valid, s_empty, s_full;
  pc_state_e   s_state;

  logic [W-1:0]  exp_q[$];
  logic [W8-1:0] exp8_q[$];
  int checks = 0;
  int errors = 0;

  pc_gen dut (
    .Clk(clk), .Clrn(clrn), .En(en), .IF_Ready(if_ready),
    .Redirect(redirect), .Redirect_Addr(redirect_addr), .Trap(trap),
    .Call_Push(call_push), .Ret_Pop(ret_pop),
    .IF_Addr(if_addr), .IF_Valid(if_valid),
    .Ras_Empty(ras_empty), .Ras_Full(ras_full), .dbg_state(dbg_state)
  );

  pc_gen #(.ADDR_W(8), .RESET_VEC(8'hF8)) dut8 (
    .Clk(clk), .Clrn(s_clrn), .En(1'b1), .IF_Ready(1'b1),
    .Redirect(1'b0), .Redirect_Addr(8'h00), .Trap(s_trap),
    .Call_Push(1'b0), .Ret_Pop(1'b0),
    .IF_Addr(s_addr), .IF_Valid(s_valid),
    .Ras_Empty(s_empty), .Ras_Full(s_full), .dbg_state(s_state)
  );

  task automatic drv(input logic c, input logic e, input logic r, input logic rd,
                     input logic [31:0] ra, input logic t, input logic p, input logic q);
    clrn = c; en = e; if_ready = r; redirect = rd;
    redirect_addr = ra; trap = t; call_push = p; ret_pop = q;
  endtask

  task automatic tick(input pc_state_e st, input logic v, input logic [31:0] a,
                      input logic e, input logic f);
    @(posedge clk);
    #1;
    exp_q.push_back({st, v, e, f, a});
  endtask

  task automatic jump(input logic [31:0] a, input logic e, input logic f);
    drv(1, 1, 1, 1, a, 0, 0, 0);
    tick(ST_FLUSH, 0, a, e, f);
    drv(1, 1, 1, 0, 0, 0, 0, 0);
    tick(ST_RUN, 1, a, e, f);
  endtask

  task automatic tick8(input pc_state_e st, input logic v, input logic [7:0] a);
    @(posedge clk);
    #1;
    exp8_q.push_back({st, v, a});
  endtask

  // Monitor: one expected observation per checked cycle, compared mid-cycle.
  always @(negedge clk) begin
    logic [W-1:0]  e, a;
    logic [W8-1:0] e8, a8;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {dbg_state, if_valid, ras_empty, ras_full, if_addr};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL main t=%0t: got st=%0d valid=%0b empty=%0b full=%0b addr=%h, expected st=%0d valid=%0b empty=%0b full=%0b addr=%h",
                 $time, a[36:35], a[34], a[33], a[32], a[31:0],
                 e[36:35], e[34], e[33], e[32], e[31:0]);
      end
    end
    if (exp8_q.size() > 0) begin
      e8 = exp8_q.pop_front();
      a8 = {s_state, s_valid, s_addr};
      checks++;
      if (a8 !== e8) begin
        errors++;
        $display("FAIL addr8 t=%0t: got st=%0d valid=%0b addr=%h, expected st=%0d valid=%0b addr=%h",
                 $time, a8[10:9], a8[8], a8[7:0], e8[10:9], e8[8], e8[7:0]);
      end
    end
  end

  initial begin
    s_clrn = 0; s_trap = 0;
    drv(0, 1, 1, 0, 0, 0, 0, 0);
    tick(ST_BOOT, 0, 32'h0, 1, 0);
    tick(ST_BOOT, 0, 32'h0, 1, 0);

    // Release: one bubble, then sequential fetch.
    drv(1, 1, 1, 0, 0, 0, 0, 0);
    tick(ST_RUN, 1, 32'h0, 1, 0);
    tick(ST_RUN, 1, 32'h4, 1, 0);
    tick(ST_RUN, 1, 32'h8, 1, 0);
    tick(ST_RUN, 1, 32'hC, 1, 0);
    tick(ST_RUN, 1, 32'h10, 1, 0);

    // Stall then backpressure, then advance.
    drv(1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(ST_RUN, 1, 32'h10, 1, 0);
    drv(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) tick(ST_RUN, 1, 32'h10, 1, 0);
    drv(1, 1, 1, 0, 0, 0, 0, 0);
    tick(ST_RUN, 1, 32'h14, 1, 0);

    // Misaligned redirect under backpressure.
    drv(1, 1, 0, 1, 32'h103, 0, 0, 0);
    tick(ST_FLUSH, 0, 32'h100, 1, 0);
    drv(1, 1, 1, 0, 0, 0, 0, 0);
    tick(ST_RUN, 1, 32'h100, 1, 0);
    tick(ST_RUN, 1, 32'h104, 1, 0);

    // Trap beats redirect, even while stalled.
    drv(1, 0, 1, 1, 32'h200, 1, 0, 0);
    tick(ST_FLUSH, 0, 32'h80, 1, 0);
    drv(1, 1, 1, 0, 0, 0, 0, 0);
    tick(ST_RUN, 1, 32'h80, 1, 0);

    // Calls at 0x20 and 0x40, returns at 0x60 and 0x70.
    jump(32'h20, 1, 0);
    drv(1, 1, 1, 0, 0, 0, 1, 0); tick(ST_RUN, 1, 32'h24, 0, 0);
    jump(32'h40, 0, 0);
    drv(1, 1, 1, 0, 0, 0, 1, 0); tick(ST_RUN, 1, 32'h44, 0, 0);
    jump(32'h60, 0, 0);
    drv(1, 1, 1, 0, 0, 0, 0, 1); tick(ST_RUN, 1, 32'h44, 0, 0);
    jump(32'h70, 0, 0);
    drv(1, 1, 1, 0, 0, 0, 0, 1); tick(ST_RUN, 1, 32'h24, 1, 0);
    drv(1, 1, 1, 0, 0, 0, 0, 0); tick(ST_RUN, 1, 32'h28, 1, 0);
    drv(1, 1, 1, 0, 0, 0, 0, 1); tick(ST_RUN, 1, 32'h2C, 1, 0);

    // Five pushes into a 4-deep stack, then drain it.
    drv(1, 1, 1, 0, 0, 0, 1, 0);
    tick(ST_RUN, 1, 32'h30, 0, 0);
    tick(ST_RUN, 1, 32'h34, 0, 0);
    tick(ST_RUN, 1, 32'h38, 0, 0);
    tick(ST_RUN, 1, 32'h3C, 0, 1);
    tick(ST_RUN, 1, 32'h40, 0, 1);
    drv(1, 1, 1, 0, 0, 0, 0, 1);
    tick(ST_RUN, 1, 32'h40, 0, 0);
    tick(ST_RUN, 1, 32'h3C, 0, 0);
    tick(ST_RUN, 1, 32'h38, 0, 0);
    tick(ST_RUN, 1, 32'h34, 1, 0);
    tick(ST_RUN, 1, 32'h38, 1, 0);

    // Push+pop in one cycle replaces the top entry.
    drv(1, 1, 1, 0, 0, 0, 1, 0); tick(ST_RUN, 1, 32'h3C, 0, 0);
    drv(1, 1, 1, 0, 0, 0, 1, 1); tick(ST_RUN, 1, 32'h3C, 0, 0);
    drv(1, 1, 1, 0, 0, 0, 0, 1); tick(ST_RUN, 1, 32'h40, 1, 0);

    // Push ignored without advance, taken with it.
    drv(1, 1, 0, 0, 0, 0, 1, 0); tick(ST_RUN, 1, 32'h40, 1, 0);
    drv(1, 1, 1, 0, 0, 0, 1, 0); tick(ST_RUN, 1, 32'h44, 0, 0);

    // Reset in FLUSH with a pending trap.
    drv(1, 1, 1, 1, 32'h500, 0, 0, 0); tick(ST_FLUSH, 0, 32'h500, 0, 0);
    drv(0, 1, 1, 0, 0, 1, 0, 0);        tick(ST_BOOT, 0, 32'h0, 1, 0);
    drv(1, 1, 1, 0, 0, 0, 0, 0);
    tick(ST_RUN, 1, 32'h0, 1, 0);
    tick(ST_RUN, 1, 32'h4, 1, 0);

    // 8-bit instance: wrap past 0xFC and truncated trap vector.
    tick8(ST_BOOT, 0, 8'hF8);
    s_clrn = 1;
    tick8(ST_RUN, 1, 8'hF8);
    tick8(ST_RUN, 1, 8'hFC);
    tick8(ST_RUN, 1, 8'h00);
    tick8(ST_RUN, 1, 8'h04);
    s_trap = 1;
    tick8(ST_FLUSH, 0, 8'h80);
    s_trap = 0;
    tick8(ST_RUN, 1, 8'h80);
    tick8(ST_RUN, 1, 8'h84);

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0 || exp8_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expected entries left, required 0", exp_q.size(), exp8_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program-counter generator for the fetch stage. Replaces the fixed 32-bit, split-edge PC register.
- Single-edge (posedge) update. Configurable address width, reset vector, step size and trap vector.
- Adds a valid/ready fetch handshake, stall and flush handling, fixed-priority redirect selection, and an internal return-address stack (RAS) for call/return prediction.

Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_VEC, 0, PC value loaded at reset.
- TRAP_VEC, 32'h0000_0080, target taken on Trap. Truncated to ADDR_W.
- STEP, 4, sequential increment. Must be a power of two, at least 1.
- RAS_DEPTH, 4, return-address stack entries. Power of two, at least 2.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Clrn  in  1  reset, synchronous, active-low.
- En  in  1  global enable; 0 = stall.
- IF_Ready  in  1  fetch stage accepts IF_Addr this cycle.
- Redirect  in  1  branch/jump resolved taken; flush.
- Redirect_Addr  in  ADDR_W  redirect target.
- Trap  in  1  exception; flush to TRAP_VEC.
- Call_Push  in  1  current fetch is a call; push IF_Addr+STEP.
- Ret_Pop  in  1  current fetch is a return; next PC = RAS top.
- IF_Addr  out  ADDR_W  current fetch address (registered).
- IF_Valid  out  1  IF_Addr is valid for fetch.
- Ras_Empty  out  1  RAS holds 0 entries.
- Ras_Full  out  1  RAS holds RAS_DEPTH entries.

Behaviour:
- One clock; reset is synchronous and active-low. While Clrn=0 at a rising edge:
  - IF_Addr <= RESET_VEC, IF_Valid <= 0.
  - RAS count <= 0, so Ras_Empty=1 and Ras_Full=0.
  - State <= BOOT.
  - Reset overrides every other input, including mid-redirect or a pending Trap.
- States:
  - BOOT: IF_Valid=0. Next edge goes to RUN with IF_Valid=1 and IF_Addr unchanged.
  - RUN: IF_Valid=1.
  - FLUSH: one bubble, IF_Valid=0. Next edge goes to RUN.
- Advance condition: adv = (state==RUN) & IF_Valid & IF_Ready & En.
- Next-PC priority, evaluated every cycle in RUN or FLUSH:
  1. Trap: IF_Addr <= TRAP_VEC, state <= FLUSH. Acts even when En=0 or IF_Ready=0.
  2. Redirect: IF_Addr <= Redirect_Addr with the low log2(STEP) bits forced to 0, state <= FLUSH. Acts even when En=0 or IF_Ready=0.
  3. adv & Ret_Pop & !Ras_Empty: IF_Addr <= RAS top; pop.
  4. adv: IF_Addr <= IF_Addr + STEP, wrapping modulo 2^ADDR_W (e.g. all-ones minus STEP+1 goes to 0).
  5. Otherwise IF_Addr holds. This covers stall (En=0) and backpressure (IF_Ready=0).
- Trap and Redirect are also accepted in BOOT. They load the target and move to FLUSH.
- Ret_Pop when Ras_Empty=1: treated as sequential (IF_Addr + STEP). The count stays 0.
- RAS updates happen only on adv, and never in a cycle with Trap or Redirect.
  - Push value is IF_Addr+STEP (wrapped).
  - Push when full: circular overwrite of the oldest entry; count stays RAS_DEPTH.
  - Push and Pop in the same adv cycle: next PC = old top; the top entry is replaced by the push value; count unchanged.
- Ras_Empty and Ras_Full are registered and reflect the count after the edge.
- Latency:
  - Redirect/Trap asserted at edge N: IF_Addr = target after N, IF_Valid=0 for one cycle, IF_Valid=1 after N+1.
  - Sequential and RAS-pop updates take effect after the same edge, with no bubble.
- Call_Push and Ret_Pop are ignored when adv=0.

Decomposition:
- Package pc_pkg holds:
  - the state encoding (BOOT, RUN, FLUSH);
  - the next-PC select enum (SEL_TRAP, SEL_REDIR, SEL_RAS, SEL_SEQ, SEL_HOLD);
  - default vector constants.
- Sub-module pc_ras (parametrised ADDR_W, RAS_DEPTH):
  - circular stack with push/pop/top;
  - same-cycle push+pop replace semantics;
  - overwrite-on-full;
  - empty/full flags.
- pc_gen holds the FSM, the priority mux and the adder.

Test Plan:
- Reset release, RESET_VEC=0, IF_Ready=1, En=1 -> IF_Valid=0 for 1 cycle, then IF_Addr=0, 4, 8, 12 on consecutive cycles.
- En=0 for 3 cycles at IF_Addr=0x10, then IF_Ready=0 for 2 cycles -> IF_Addr holds 0x10 for all 5 cycles, then advances to 0x14.
- Redirect with Redirect_Addr=0x103 while IF_Ready=0 -> IF_Addr=0x100, one IF_Valid=0 bubble, then 0x100, 0x104. Trap and Redirect together -> IF_Addr=0x80.
- Call_Push at 0x20 and 0x40, then Ret_Pop at 0x60 and 0x70 -> next PCs 0x44 then 0x24, Ras_Empty=1 afterwards. A further Ret_Pop at 0x28 -> 0x2C.
- Five pushes with RAS_DEPTH=4 -> Ras_Full=1 and the oldest entry is lost. Four pops return the last four push values in reverse order.
- ADDR_W=8, IF_Addr=0xFC, adv -> IF_Addr=0x00. Clrn=0 asserted in FLUSH -> IF_Addr=RESET_VEC, IF_Valid=0, state BOOT.
